ifu_fetch_queue: RTL and testbench

- Parametrised instruction-fetch unit for the ysyx_22040175 core; the next generation of the single-cycle top's combinational fetch.
- Replaces that fetch with a decoupled path: a valid/ready request to instruction memory, in-order responses, and a DEPTH-entry instruction queue feeding decode.
- Handles branch/jump redirects: the queue is flushed and stale in-flight responses are dropped.
- Sits between the PC-select logic (muxpc) and ctrl/imm_gen.

---
 rtl/ifu_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: decoupled instruction fetch with an in-order request
// path, a PC FIFO for in-flight requests and a DEPTH-entry instruction queue.
// Ports: clk, rst_n (async, active low); redirect_valid/redirect_pc;
//   mem_req_valid/ready/addr; mem_rsp_valid/data; inst_valid/ready, inst, inst_pc.
// Optional: define IFU_PERF_EN to add perf_fetch_cnt/perf_stall_cnt/perf_drop_cnt.
module ifu_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt,
    output logic [63:0]       perf_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_U = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   fetch_pc;
    logic [CW-1:0]     count, outstanding, drop_cnt;
    logic [CW-1:0]     out_nx, drop_nx;
    logic [CW:0]       used;
    logic [AW-1:0]     pf_wr, pf_rd, q_wr, q_rd;
    logic [XLEN-1:0]   pf_mem [DEPTH];
    logic [XLEN-1:0]   q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic              req_fire, rsp_fire, push, pop;
    logic [XLEN-1:0]   rsp_pc;
    logic [INST_W-1:0] rsp_inst;

    // Credit: in-flight requests plus queued entries never exceed DEPTH,
    // so every response has a free queue slot.
    assign used          = {1'b0, outstanding} + {1'b0, count};
    assign mem_req_valid = (state == RUN) && !redirect_valid && (used < DEPTH_U);
    assign mem_req_addr  = fetch_pc;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_fire = mem_rsp_valid && (outstanding != '0);
    assign pop      = inst_valid && inst_ready;
    assign push     = rsp_fire && !redirect_valid && (drop_cnt == '0);

    assign rsp_pc = pf_mem[pf_rd];

    generate
        if (INST_W == XLEN) begin : g_full
            assign rsp_inst = mem_rsp_data;
        end else begin : g_half
            assign rsp_inst = rsp_pc[2] ? mem_rsp_data[XLEN-1:INST_W]
                                        : mem_rsp_data[INST_W-1:0];
        end
    endgenerate

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[q_rd] : '0;
    assign inst_pc    = inst_valid ? q_pc[q_rd]   : '0;

    always_comb begin
        out_nx   = outstanding + CW'(req_fire) - CW'(rsp_fire);
        drop_nx  = drop_cnt;
        state_nx = state;
        // Everything still in flight after a redirect is stale.
        if (redirect_valid) begin
            drop_nx = out_nx;
        end else if (rsp_fire && (drop_cnt != '0)) begin
            drop_nx = drop_cnt - CW'(1);
        end
        case (state)
            BOOT:    state_nx = RUN;
            RUN:     if (redirect_valid && (out_nx != '0)) state_nx = FLUSH;
            FLUSH:   if (drop_nx == '0) state_nx = RUN;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            pf_wr       <= '0;
            pf_rd       <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            state       <= state_nx;
            outstanding <= out_nx;
            drop_cnt    <= drop_nx;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (req_fire) pf_wr <= pf_wr + AW'(1);
            if (rsp_fire) pf_rd <= pf_rd + AW'(1);
            if (redirect_valid) begin
                count <= '0;
                q_rd  <= q_wr;
            end else begin
                if (push) q_wr <= q_wr + AW'(1);
                if (pop)  q_rd <= q_rd + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pf_mem[pf_wr] <= fetch_pc;
        if (push) begin
            q_pc[q_wr]   <= rsp_pc;
            q_inst[q_wr] <= rsp_inst;
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (req_fire && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if ((state == RUN) && !inst_valid && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            if (rsp_fire && !push && (perf_drop_cnt != '1))
                perf_drop_cnt <= perf_drop_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed vector table plus hand sequences for
// ifu_fetch_queue (XLEN=64, INST_W=32, DEPTH=4), with a 1-cycle memory.
module tb_ifu_fetch_queue;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt, perf_drop_cnt;
`endif

    ifu_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        rsp_en;
        logic        ir;
        logic        erv;
        logic [63:0] eaddr;
        logic        eiv;
        logic [63:0] epc;
    } vec_t;

    vec_t        tbl [34];
    logic [63:0] pend [$];
    int          checks = 0;
    int          errors = 0;
    int          fetches = 0;

    function automatic logic [63:0] word(logic [63:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {(b + 32'd4) ^ 32'hA500_0000, b ^ 32'h5A00_0000};
    endfunction

    function automatic logic [31:0] exp_inst(logic [63:0] pc);
        logic [63:0] w;
        w = word(pc);
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic vec_t mk(logic redir, logic [63:0] rpc, logic rsp_en,
                                logic ir, logic erv, logic [63:0] aoff,
                                logic eiv, logic [63:0] poff);
        vec_t v;
        v.redir  = redir;
        v.rpc    = rpc;
        v.rsp_en = rsp_en;
        v.ir     = ir;
        v.erv    = erv;
        v.eaddr  = B + aoff;
        v.eiv    = eiv;
        v.epc    = eiv ? B + poff : 64'd0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, " req_addr"}, mem_req_addr, B);
        chk({tag, " inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, " inst"}, 64'(inst), 64'd0);
        chk({tag, " inst_pc"}, inst_pc, 64'd0);
    endtask

    task automatic step(input vec_t v, input string tag);
        logic        req_hs, rsp_hs;
        logic [63:0] hs_addr;
        @(negedge clk);
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        inst_ready     = v.ir;
        mem_req_ready  = 1'b1;
        if (v.rsp_en && pend.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word(pend[0]);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
        chk({tag, " req_valid"}, 64'(mem_req_valid), 64'(v.erv));
        chk({tag, " req_addr"}, mem_req_addr, v.eaddr);
        chk({tag, " inst_valid"}, 64'(inst_valid), 64'(v.eiv));
        chk({tag, " inst_pc"}, inst_pc, v.epc);
        chk({tag, " inst"}, 64'(inst),
            v.eiv ? 64'(exp_inst(v.epc)) : 64'd0);
        req_hs  = mem_req_valid && mem_req_ready;
        hs_addr = mem_req_addr;
        rsp_hs  = mem_rsp_valid;
        @(posedge clk);
        if (rsp_hs) void'(pend.pop_front());
        if (req_hs) begin
            pend.push_back(hs_addr);
            fetches++;
        end
    endtask

    initial begin
        // streaming, 1-cycle memory
        tbl[0]  = mk(0, 0, 1, 1, 0, 'h00, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 1, 'h00, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 1, 'h04, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 1, 'h08, 1, 'h00);
        tbl[4]  = mk(0, 0, 1, 1, 1, 'h0C, 1, 'h04);
        tbl[5]  = mk(0, 0, 1, 1, 1, 'h10, 1, 'h08);
        // decode stalls: credit fills, requests stop
        tbl[6]  = mk(0, 0, 1, 0, 1, 'h14, 1, 'h0C);
        tbl[7]  = mk(0, 0, 1, 0, 1, 'h18, 1, 'h0C);
        tbl[8]  = mk(0, 0, 1, 0, 0, 'h1C, 1, 'h0C);
        tbl[9]  = mk(0, 0, 1, 0, 0, 'h1C, 1, 'h0C);
        // drain in order, requests resume
        tbl[10] = mk(0, 0, 1, 1, 0, 'h1C, 1, 'h0C);
        tbl[11] = mk(0, 0, 1, 1, 1, 'h1C, 1, 'h10);
        tbl[12] = mk(0, 0, 1, 1, 1, 'h20, 1, 'h14);
        tbl[13] = mk(0, 0, 1, 1, 1, 'h24, 1, 'h18);
        tbl[14] = mk(0, 0, 1, 1, 1, 'h28, 1, 'h1C);
        tbl[15] = mk(0, 0, 1, 1, 1, 'h2C, 1, 'h20);
        // memory stalls to build 3 outstanding, then redirect
        tbl[16] = mk(0, 0, 0, 1, 1, 'h30, 1, 'h24);
        tbl[17] = mk(0, 0, 0, 0, 1, 'h34, 1, 'h28);
        tbl[18] = mk(1, B + 'h103, 0, 0, 0, 'h38, 1, 'h28);
        tbl[19] = mk(0, 0, 1, 1, 0, 'h100, 0, 0);
        tbl[20] = mk(0, 0, 1, 1, 0, 'h100, 0, 0);
        tbl[21] = mk(0, 0, 1, 1, 0, 'h100, 0, 0);
        tbl[22] = mk(0, 0, 1, 1, 1, 'h100, 0, 0);
        tbl[23] = mk(0, 0, 1, 1, 1, 'h104, 0, 0);
        tbl[24] = mk(0, 0, 1, 1, 1, 'h108, 1, 'h100);
        tbl[25] = mk(0, 0, 1, 1, 1, 'h10C, 1, 'h104);
        // redirect with same-cycle response and inst handshake
        tbl[26] = mk(0, 0, 0, 1, 1, 'h110, 1, 'h108);
        tbl[27] = mk(0, 0, 1, 1, 1, 'h114, 0, 0);
        tbl[28] = mk(1, B + 'h200, 1, 1, 0, 'h118, 1, 'h10C);
        tbl[29] = mk(0, 0, 1, 1, 0, 'h200, 0, 0);
        tbl[30] = mk(0, 0, 1, 1, 1, 'h200, 0, 0);
        tbl[31] = mk(0, 0, 1, 1, 1, 'h204, 0, 0);
        tbl[32] = mk(0, 0, 1, 1, 1, 'h208, 1, 'h200);
        tbl[33] = mk(0, 0, 0, 0, 1, 'h20C, 1, 'h204);

        @(negedge clk);
        #1;
        chk_reset("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
`ifdef IFU_PERF_EN
            if (i == 22) begin
                chk("perf_drop", perf_drop_cnt, 64'd3);
                chk("perf_fetch", perf_fetch_cnt, 64'(fetches));
            end
`endif
            step(tbl[i], $sformatf("r%0d", i));
        end

        // async reset mid-stream: 2 outstanding, 1 queued
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mem_rsp_valid  = 1'b0;
        #1;
        chk("pre_rst inst_pc", inst_pc, B + 'h204);
        chk("pre_rst req_addr", mem_req_addr, B + 'h210);
        #1 rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // stale responses for 0x208/0x20C arrive while outstanding is 0
        step(mk(0, 0, 1, 1, 0, 'h00, 0, 0), "p0");
        step(mk(0, 0, 1, 1, 1, 'h00, 0, 0), "p1");
        step(mk(0, 0, 1, 1, 1, 'h04, 0, 0), "p2");
        step(mk(0, 0, 1, 1, 1, 'h08, 1, 'h00), "p3");
        step(mk(0, 0, 1, 1, 1, 'h0C, 1, 'h04), "p4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
